// File: rtl/coin_pkg.sv
// Shared coin codes, debounce state encoding and the default debounce length
// for the coin acceptor slice.
package coin_pkg;

  localparam int DEBOUNCE_CYCLES_DEF = 8;

  localparam logic [1:0] COIN_NONE   = 2'b00;
  localparam logic [1:0] COIN_NICKEL = 2'b01;
  localparam logic [1:0] COIN_DIME   = 2'b10;

  typedef enum logic [2:0] {
    DB_ARM     = 3'd0,
    DB_IDLE    = 3'd1,
    DB_CONFIRM = 3'd2,
    DB_ACTIVE  = 3'd3,
    DB_RELEASE = 3'd4
  } db_state_e;

endpackage

// File: rtl/coin_debounce.sv
// Two-flop synchronizer plus debounce FSM for one coin sensor; emits a
// registered one-cycle event each time the sensor settles high.
module coin_debounce
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic raw_i,
  output logic event_o
);

  localparam logic [7:0] RUN_LAST = 8'(DEBOUNCE_CYCLES - 1);

  logic [1:0] sync_q;
  db_state_e  state_q, state_d;
  logic [7:0] cnt_q, cnt_d;
  logic       event_q, event_d;
  logic       sample_s;
  logic       last_s;

  assign sample_s = sync_q[1];
  // The current sample is the one that completes the run.
  assign last_s   = (cnt_q == RUN_LAST);
  assign event_o  = event_q;

  // State, run counter, synchronizer and event register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync_q  <= 2'b00;
      state_q <= DB_ARM;
      cnt_q   <= 8'd0;
      event_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[0], raw_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
      event_q <= event_d;
    end
  end

  // Next state and run counter.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      DB_ARM: begin
        if (sample_s) begin
          cnt_d = 8'd0;
        end else if (last_s) begin
          state_d = DB_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DB_IDLE: begin
        if (sample_s) begin
          state_d = DB_CONFIRM;
          cnt_d   = 8'd1;
        end else begin
          cnt_d = 8'd0;
        end
      end
      DB_CONFIRM: begin
        if (!sample_s) begin
          state_d = DB_IDLE;
          cnt_d   = 8'd0;
        end else if (last_s) begin
          state_d = DB_ACTIVE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      DB_ACTIVE: begin
        if (!sample_s) begin
          state_d = DB_RELEASE;
          cnt_d   = 8'd1;
        end else begin
          cnt_d = 8'd0;
        end
      end
      DB_RELEASE: begin
        if (sample_s) begin
          state_d = DB_ACTIVE;
          cnt_d   = 8'd0;
        end else if (last_s) begin
          state_d = DB_IDLE;
          cnt_d   = 8'd0;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: begin
        state_d = DB_ARM;
        cnt_d   = 8'd0;
      end
    endcase
  end

  // A bounce back from RELEASE is the same coin, so only CONFIRM->ACTIVE fires.
  always_comb begin
    if ((state_q == DB_CONFIRM) && (state_d == DB_ACTIVE)) begin
      event_d = 1'b1;
    end else begin
      event_d = 1'b0;
    end
  end

endmodule

// File: rtl/coin_acceptor.sv
// Coin acceptor: two debounced sensors feed a coin queue that issues one
// coin code per slot with a mandatory idle gap. COIN_ACCEPTOR_FIFO_EN selects
// a 4-deep queue; otherwise a single holding register is used.
module coin_acceptor
  import coin_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       nickel_raw,
  input  logic       dime_raw,
  input  logic       vend_busy,
  output logic [1:0] coin,
  output logic       reject,
  output logic [2:0] pending
);

  logic       ev_nickel_s, ev_dime_s;
  logic       ev_single_s, ev_both_s;
  logic [1:0] ev_code_s;
  logic       full_s, empty_s;
  logic [1:0] head_s;
  logic       enq_s, deq_s;
  logic [1:0] coin_q, coin_d;
  logic       reject_q, reject_d;

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_nickel (
    .clk_i  (clk),
    .rst_ni (rst),
    .raw_i  (nickel_raw),
    .event_o(ev_nickel_s)
  );

  coin_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dime (
    .clk_i  (clk),
    .rst_ni (rst),
    .raw_i  (dime_raw),
    .event_o(ev_dime_s)
  );

  assign ev_both_s   = ev_nickel_s & ev_dime_s;
  assign ev_single_s = ev_nickel_s ^ ev_dime_s;
  assign ev_code_s   = ev_nickel_s ? COIN_NICKEL : COIN_DIME;
  assign enq_s       = ev_single_s & ~full_s;
  // Issuing only when coin was idle last cycle forces the gap for nw_pa.
  assign deq_s       = ~empty_s & ~vend_busy & (coin_q == COIN_NONE);

`ifdef COIN_ACCEPTOR_FIFO_EN
  logic [1:0] mem_q [4];
  logic [1:0] wr_ptr_q, rd_ptr_q;
  logic [2:0] cnt_q, cnt_d;

  assign head_s  = mem_q[rd_ptr_q];
  assign full_s  = (cnt_q == 3'd4);
  assign empty_s = (cnt_q == 3'd0);
  assign pending = cnt_q;

  // Occupancy update; simultaneous push and pop leave it unchanged.
  always_comb begin
    case ({enq_s, deq_s})
      2'b10:   cnt_d = cnt_q + 3'd1;
      2'b01:   cnt_d = cnt_q - 3'd1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Queue storage and wrapping pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < 4; i++) begin
        mem_q[i] <= COIN_NONE;
      end
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      cnt_q    <= 3'd0;
    end else begin
      if (enq_s) begin
        mem_q[wr_ptr_q] <= ev_code_s;
        wr_ptr_q        <= wr_ptr_q + 2'd1;
      end
      if (deq_s) begin
        rd_ptr_q <= rd_ptr_q + 2'd1;
      end
      cnt_q <= cnt_d;
    end
  end
`else
  logic [1:0] hold_q;
  logic       full_q, full_d;

  assign head_s  = hold_q;
  assign full_s  = full_q;
  assign empty_s = ~full_q;
  assign pending = {2'b00, full_q};

  // A single slot cannot be pushed and popped together.
  always_comb begin
    case ({enq_s, deq_s})
      2'b10:   full_d = 1'b1;
      2'b01:   full_d = 1'b0;
      default: full_d = full_q;
    endcase
  end

  // Holding register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hold_q <= COIN_NONE;
      full_q <= 1'b0;
    end else begin
      if (enq_s) begin
        hold_q <= ev_code_s;
      end
      full_q <= full_d;
    end
  end
`endif

  // Issue and reject decisions.
  always_comb begin
    if (deq_s) begin
      coin_d = head_s;
    end else begin
      coin_d = COIN_NONE;
    end
    reject_d = ev_both_s | (ev_single_s & full_s);
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      coin_q   <= COIN_NONE;
      reject_q <= 1'b0;
    end else begin
      coin_q   <= coin_d;
      reject_q <= reject_d;
    end
  end

  assign coin   = coin_q;
  assign reject = reject_q;

endmodule

// File: tb/tb_coin_acceptor.sv
// Scoreboard bench for coin_acceptor: stimulus pushes expected coin codes,
// a negedge monitor pops and compares every issued coin.
module tb_coin_acceptor;

`ifdef COIN_ACCEPTOR_FIFO_EN
  localparam int QDEPTH = 4;
`else
  localparam int QDEPTH = 1;
`endif

  logic       clk;
  logic       rst;
  logic       nickel_raw;
  logic       dime_raw;
  logic       vend_busy;
  logic [1:0] coin;
  logic       reject;
  logic [2:0] pending;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int rej_seen = 0;
  int coins_seen = 0;
  int last_cyc = -100;
  int prev_cyc = -100;
  bit prev_nz  = 1'b0;
  logic [1:0] exp_q [$];

  coin_acceptor dut (
    .clk       (clk),
    .rst       (rst),
    .nickel_raw(nickel_raw),
    .dime_raw  (dime_raw),
    .vend_busy (vend_busy),
    .coin      (coin),
    .reject    (reject),
    .pending   (pending)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input int act, input int exp_v);
    n_checks++;
    if (act != exp_v) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", nm, act, exp_v, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Monitor: every issued coin is checked against the scoreboard.
  logic [1:0] exp_code;
  always @(negedge clk) begin
    if (rst) begin
      if (reject) rej_seen++;
      if (coin != 2'b00) begin
        chk("coin_gap", int'(prev_nz), 0);
        if (exp_q.size() == 0) begin
          chk("unexpected_coin", int'(coin), 0);
        end else begin
          exp_code = exp_q.pop_front();
          chk("coin_value", int'(coin), int'(exp_code));
        end
        prev_cyc = last_cyc;
        last_cyc = cyc;
        coins_seen++;
      end
      prev_nz = (coin != 2'b00);
    end else begin
      prev_nz = 1'b0;
    end
  end

  task automatic pulse_nickel(input int hi);
    nickel_raw = 1'b1; tick(hi);
    nickel_raw = 1'b0; tick(14);
  endtask

  task automatic pulse_dime(input int hi);
    dime_raw = 1'b1; tick(hi);
    dime_raw = 1'b0; tick(14);
  endtask

  initial begin
    int t0;
    int rej0;
    int seen0;
    rst = 1'b0; nickel_raw = 1'b0; dime_raw = 1'b0; vend_busy = 1'b0;
    tick(3);
    chk("reset_coin", int'(coin), 0);
    chk("reset_reject", int'(reject), 0);
    chk("reset_pending", int'(pending), 0);
    rst = 1'b1;
    tick(14);

    // Single nickel: coin 01 exactly 12 cycles after the drive (edge N+3).
    exp_q.push_back(2'b01);
    t0 = cyc;
    pulse_nickel(20);
    chk("nickel_latency", last_cyc, t0 + 12);
    chk("nickel_seen", coins_seen, 1);
    chk("nickel_reject", rej_seen, 0);
    chk("nickel_pending", int'(pending), 0);

    // Glitch shorter than the debounce window.
    pulse_dime(5);
    chk("glitch_seen", coins_seen, 1);
    chk("glitch_reject", rej_seen, 0);

    // Simultaneous rise on both sensors.
    nickel_raw = 1'b1; dime_raw = 1'b1; tick(20);
    nickel_raw = 1'b0; dime_raw = 1'b0; tick(14);
    chk("simul_reject", rej_seen, 1);
    chk("simul_pending", int'(pending), 0);
    chk("simul_seen", coins_seen, 1);

    // Backpressure: three dimes held while busy, then released.
    vend_busy = 1'b1;
    rej0 = rej_seen;
    repeat (3) begin
      if (QDEPTH > 1) exp_q.push_back(2'b10);
      pulse_dime(12);
    end
    if (QDEPTH == 1) exp_q.push_back(2'b10);
    chk("busy_pending", int'(pending), (QDEPTH > 1) ? 3 : 1);
    chk("busy_reject", rej_seen - rej0, (QDEPTH > 1) ? 0 : 2);
    chk("busy_seen", coins_seen, 1);
    vend_busy = 1'b0;
    tick(10);
    chk("drain_pending", int'(pending), 0);
    chk("drain_seen", coins_seen, (QDEPTH > 1) ? 4 : 2);
    if (QDEPTH > 1) chk("drain_spacing", last_cyc - prev_cyc, 2);

    // Overflow while busy.
    vend_busy = 1'b1;
    rej0 = rej_seen;
    seen0 = coins_seen;
    repeat (QDEPTH + 1) pulse_nickel(12);
    repeat (QDEPTH) exp_q.push_back(2'b01);
    chk("ovf_pending", int'(pending), QDEPTH);
    chk("ovf_reject", rej_seen - rej0, 1);
    vend_busy = 1'b0;
    tick(12);
    chk("ovf_drain_seen", coins_seen - seen0, QDEPTH);
    chk("ovf_drain_pending", int'(pending), 0);

    // Reset mid-run with a sensor held high across reset release.
    vend_busy = 1'b1;
    rej0 = rej_seen;
    repeat (2) pulse_nickel(12);
    chk("pre_rst_pending", int'(pending), (QDEPTH > 1) ? 2 : 1);
    chk("pre_rst_reject", rej_seen - rej0, (QDEPTH > 1) ? 0 : 1);
    seen0 = coins_seen;
    nickel_raw = 1'b1; tick(3);
    rst = 1'b0; tick(2);
    chk("rst_pending", int'(pending), 0);
    chk("rst_coin", int'(coin), 0);
    rst = 1'b1; vend_busy = 1'b0;
    tick(20);
    chk("held_pending", int'(pending), 0);
    chk("held_seen", coins_seen - seen0, 0);
    nickel_raw = 1'b0; tick(15);
    exp_q.push_back(2'b01);
    pulse_nickel(20);
    chk("rearm_seen", coins_seen - seen0, 1);
    chk("rearm_pending", int'(pending), 0);

    tick(5);
    chk("scoreboard_empty", exp_q.size(), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/coin_acceptor.md
COIN_ACCEPTOR -- requirements
Module: coin_acceptor

Interface
REQ-001 Parameter: DEBOUNCE_CYCLES, default 8, is the number of consecutive identical synchronized samples needed to accept a sensor level change (range 2..255).
REQ-002 Port: clk  input  1  the single clock for all state.
REQ-003 Port: rst  input  1  asynchronous, active-low reset; all state resets while rst==0.
REQ-004 Port: nickel_raw  input  1  asynchronous nickel sensor; high while a coin is present.
REQ-005 Port: dime_raw  input  1  asynchronous dime sensor; high while a coin is present.
REQ-006 Port: vend_busy  input  1  downstream vend indication (wired to nw_pa); while high, no coin is issued.
REQ-007 Port: coin  output  2  registered coin code to the vending FSM: 00 none, 01 nickel, 10 dime; 11 never driven.
REQ-008 Port: reject  output  1  registered one-cycle pulse commanding coin return.
REQ-009 Port: pending  output  3  registered count of accepted coins not yet issued.

Function
REQ-010 Each raw input SHALL pass through a 2-flop synchronizer before any use.
REQ-011 Each sensor SHALL have a debounce FSM with states ARM, IDLE, CONFIRM, ACTIVE, RELEASE and an 8-bit run counter.
REQ-012 ARM -> IDLE after DEBOUNCE_CYCLES consecutive low samples; a high sample clears the counter.
REQ-013 IDLE -> CONFIRM on a high sample; CONFIRM -> ACTIVE after DEBOUNCE_CYCLES consecutive high samples; any low sample in CONFIRM -> IDLE.
REQ-014 Entering ACTIVE SHALL raise a one-cycle coin event; ACTIVE -> RELEASE on a low sample; RELEASE -> IDLE after DEBOUNCE_CYCLES consecutive lows; a high sample in RELEASE -> ACTIVE without a new event.
REQ-015 Nickel and dime events on the same cycle SHALL be dropped and reject pulsed for one cycle.
REQ-016 A single event SHALL be enqueued (01 or 10) on that cycle; if the queue is full, the event is dropped and reject pulsed.
REQ-017 coin SHALL be non-00 for exactly one cycle per issued entry; it issues the queue head when the queue is non-empty, vend_busy==0, and coin was 00 the previous cycle.
REQ-018 coin SHALL never be non-00 on two consecutive cycles; this mandatory gap lets nw_pa assert before the next issue.
REQ-019 Enqueue and dequeue on the same cycle SHALL both take effect, and pending remains unchanged.
REQ-020 Latency: raw rising edge sampled at edge 0 with an empty queue and idle output -> coin non-00 during the cycle after edge DEBOUNCE_CYCLES+3.
REQ-021 Issue order SHALL be FIFO; the queue pointers wrap modulo the depth.

Reset
REQ-022 While rst==0: coin=00, reject=0, pending=0, the queue is empty, synchronizers are 0, and both debounce FSMs are in ARM with counters 0.
REQ-023 Reset asserted mid-operation SHALL discard queued coins; a sensor held high across reset release SHALL NOT produce an event until it has been low for DEBOUNCE_CYCLES.

Configuration
REQ-024 With COIN_ACCEPTOR_FIFO_EN defined, the queue is 4 entries deep and pending ranges 0..4.
REQ-025 Without COIN_ACCEPTOR_FIFO_EN, the queue is a single holding register, pending ranges 0..1, pending[2] is tied to 0, and overflow rejects per REQ-016.

Structure
REQ-026 Package coin_pkg SHALL hold the coin code constants (COIN_NONE=00, COIN_NICKEL=01, COIN_DIME=10), the debounce state encoding, and the DEBOUNCE_CYCLES default.
REQ-027 Sub-module coin_debounce (synchronizer + debounce FSM + event output) SHALL be instantiated twice; the queue and issue logic live in coin_acceptor.

Verification
REQ-028 Single nickel: nickel_raw high for 20 cycles with DEBOUNCE_CYCLES=8 -> coin=01 for one cycle, 11 cycles after the rise; reject stays 0.
REQ-029 Glitch: dime_raw high for 5 cycles -> no coin, no reject; the FSM returns to IDLE.
REQ-030 Simultaneous: both raws rise on the same cycle for 20 cycles -> reject pulse, pending stays 0, coin stays 00.
REQ-031 Busy/backpressure: 3 dimes queued while vend_busy=1 -> pending=3, coin=00; on release, coin is 10, 00, 10, 00, 10.
REQ-032 Overflow (FIFO_EN): 5 nickels with vend_busy=1 -> pending=4 and one reject pulse; without the macro, 2 nickels -> pending=1 and one reject pulse.
REQ-033 Reset mid-run: 2 coins queued, rst pulsed low while nickel_raw is held high -> pending=0, coin=00, and no event until nickel_raw has been low for 8 cycles and then rises again.
